// File: rtl/l2_splice_loader.sv
// rtl/l2_splice_loader.sv - fills the L2 register splice from a byte stream and hands the vector on
module l2_splice_loader #(
  parameter int NBYTES = 12,
  parameter int SEL_W  = 4,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [7:0]        splice_din,
  output logic [SEL_W-1:0]  splice_sel,
  output logic              splice_we,
  output logic              splice_zero,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NBYTES - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   lane, lane_nxt;
  logic [FCNT_W-1:0]  fcnt_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      lane      <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      lane      <= lane_nxt;
      frame_cnt <= fcnt_nxt;
    end
  end

  // Splice write strobes are combinational so a byte lands on the same edge it is accepted.
  always_comb begin
    state_nxt   = state;
    lane_nxt    = lane;
    fcnt_nxt    = frame_cnt;
    in_ready    = 1'b0;
    splice_we   = 1'b0;
    splice_sel  = '0;
    splice_din  = '0;
    splice_zero = 1'b1;
    vec_valid   = 1'b0;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          lane_nxt  = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          splice_we  = 1'b1;
          splice_sel = lane;
          splice_din = in_data;
          if (lane == LAST_LANE) begin
            state_nxt = HOLD;
            lane_nxt  = '0;
          end else begin
            lane_nxt = lane + SEL_W'(1);
          end
        end
      end
      HOLD: begin
        vec_valid   = 1'b1;
        splice_zero = 1'b0;
        if (vec_ready) begin
          fcnt_nxt = frame_cnt + FCNT_W'(1);
          if (start) begin
            state_nxt = LOAD;
            lane_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides everything, including a handshake that would otherwise complete.
    if (abort) begin
      state_nxt  = IDLE;
      lane_nxt   = '0;
      fcnt_nxt   = frame_cnt;
      in_ready   = 1'b0;
      splice_we  = 1'b0;
      splice_sel = '0;
      splice_din = '0;
    end
  end

endmodule

// File: tb/tb_l2_splice_loader.sv
// tb/tb_l2_splice_loader.sv - randomized transaction-level bench for l2_splice_loader
module tb_l2_splice_loader;

  localparam int NBYTES = 12;
  localparam int SEL_W  = 4;
  localparam int FCNT_W = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              vec_ready = 1'b0;
  logic              in_ready, splice_we, splice_zero, vec_valid, busy;
  logic [7:0]        splice_din;
  logic [SEL_W-1:0]  splice_sel;
  logic [FCNT_W-1:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fc   = 0;
  logic [7:0] exp_bytes  [NBYTES];
  logic [7:0] splice_mem [2**SEL_W];

  always #5 clk = ~clk;

  l2_splice_loader #(.NBYTES(NBYTES), .SEL_W(SEL_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .splice_din(splice_din), .splice_sel(splice_sel), .splice_we(splice_we),
    .splice_zero(splice_zero), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // Behavioural splice register file fed by the loader's write port.
  always @(posedge clk) if (splice_we) splice_mem[splice_sel] <= splice_din;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] splice_vec();
    logic [127:0] v = '0;
    for (int i = 0; i < NBYTES; i++) v[8*i +: 8] = splice_mem[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_vec();
    logic [127:0] v = '0;
    for (int i = 0; i < NBYTES; i++) v[8*i +: 8] = exp_bytes[i];
    return v;
  endfunction

  task automatic drive(input logic s, input logic a, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    start = s; abort = a; in_valid = v; in_data = d; vec_ready = r;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_zero"},  splice_zero, 1'b1);
    check({tag, "_vv"},    vec_valid, 1'b0);
    check({tag, "_rdy"},   in_ready, 1'b0);
    check({tag, "_we"},    splice_we, 1'b0);
    check({tag, "_sel"},   splice_sel, '0);
    check({tag, "_fcnt"},  frame_cnt, exp_fc[FCNT_W-1:0]);
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_idle("start");
  endtask

  // mode 0: in_valid always high, 1: valid on alternate cycles, 2: random gaps
  task automatic load_bytes(input int n, input int mode, input bit fixed, output int cycles);
    int idx = 0;
    cycles = 0;
    while (idx < n && cycles < 200) begin
      logic v;
      logic [7:0] d;
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cycles % 2) == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = fixed ? 8'(8'h10 + idx) : 8'($urandom);
      drive(1'b0, 1'b0, v, d, 1'b0);
      check("load_rdy",  in_ready, 1'b1);
      check("load_zero", splice_zero, 1'b1);
      check("load_busy", busy, 1'b1);
      check("load_fcnt", frame_cnt, exp_fc[FCNT_W-1:0]);
      check("load_we",   splice_we, v);
      if (v) begin
        check("load_sel", splice_sel, idx);
        check("load_din", splice_din, d);
        exp_bytes[idx] = d;
        idx++;
      end
      cycles++;
    end
    if (idx < n) check("load_timeout", idx, n);
  endtask

  task automatic hold_and_consume(input int waits, input bit b2b);
    for (int i = 0; i < waits; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      check("hold_vv",   vec_valid, 1'b1);
      check("hold_zero", splice_zero, 1'b0);
      check("hold_we",   splice_we, 1'b0);
      check("hold_rdy",  in_ready, 1'b0);
      check("hold_fcnt", frame_cnt, exp_fc[FCNT_W-1:0]);
    end
    drive(b2b, 1'b0, 1'b0, 8'h00, 1'b1);
    check("consume_vv",  vec_valid, 1'b1);
    check("consume_vec", splice_vec(), exp_vec());
    exp_fc++;
    if (!b2b) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_idle("after_consume");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit in_load;
    bit b2b;

    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_din", splice_din, 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    // Contiguous stream 0x10..0x1B, five stalled HOLD cycles, then consume to IDLE.
    start_frame();
    load_bytes(NBYTES, 0, 1'b1, cyc);
    check("t1_load_cycles", cyc, 12);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t1_vv", vec_valid, 1'b1);
    check("t1_vec", splice_vec(), 128'h1B1A_1918_1716_1514_1312_1110);
    hold_and_consume(4, 1'b0);
    check("t1_fcnt", frame_cnt, 1);

    // Alternating in_valid, then back-to-back start with vec_ready.
    start_frame();
    load_bytes(NBYTES, 1, 1'b1, cyc);
    check("t2_load_cycles", cyc, 23);
    hold_and_consume(2, 1'b1);
    load_bytes(NBYTES, 2, 1'b0, cyc);
    hold_and_consume(0, 1'b0);

    // Abort after five bytes, abort beating start, then a clean reload.
    start_frame();
    load_bytes(5, 0, 1'b0, cyc);
    drive(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
    check("abort_we",  splice_we, 1'b0);
    check("abort_rdy", in_ready, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_idle("abort");
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_idle("abort_start");
    start_frame();
    load_bytes(NBYTES, 2, 1'b0, cyc);
    hold_and_consume(1, 1'b0);

    // Abort during a HOLD handshake must not count the frame.
    start_frame();
    load_bytes(NBYTES, 0, 1'b0, cyc);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_idle("abort_hold");

    // Random frames past the counter wrap point.
    in_load = 1'b0;
    for (int f = 0; f < 270; f++) begin
      if (!in_load) start_frame();
      load_bytes(NBYTES, 2, 1'b0, cyc);
      b2b = ((exp_fc % (1 << FCNT_W)) == (1 << FCNT_W) - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      hold_and_consume($urandom_range(0, 3), b2b);
      in_load = b2b;
      if (!b2b && (exp_fc % (1 << FCNT_W)) == 0) check("wrap", frame_cnt, 0);
    end
    if (in_load) begin
      load_bytes(NBYTES, 0, 1'b0, cyc);
      hold_and_consume(0, 1'b0);
    end

    // Asynchronous reset in the middle of LOAD.
    start_frame();
    load_bytes(4, 0, 1'b0, cyc);
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    rstn = 1'b0;
    exp_fc = 0;
    #1;
    check_idle("async_rst");
    check("async_rst_din", splice_din, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    in_valid = 1'b0;
    start_frame();
    load_bytes(NBYTES, 2, 1'b0, cyc);
    hold_and_consume(1, 1'b0);
    check("post_rst_fcnt", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
